// File: rtl/hash_pipe_arbiter.sv
// Round-robin arbiter feeding a fixed-latency hash datapath. Each in-flight operation is tagged
// with its requester, and requests whose bucket matches an in-flight operation are held off.
module hash_pipe_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int DATA_WIDTH  = 32,
    parameter int NPIPE_DEPTH = 2,
    parameter int BUCKET_BITS = 8,
    localparam int ID_WIDTH   = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          pipe_in_valid,
    output logic [DATA_WIDTH-1:0]         pipe_in_data,
    input  logic [DATA_WIDTH-1:0]         pipe_out_data,
    output logic                          resp_valid,
    output logic [ID_WIDTH-1:0]           resp_id,
    output logic [DATA_WIDTH-1:0]         resp_data,
    output logic                          busy,
    output logic [31:0]                   stall_count
);

    localparam int PIPE_LATENCY = NPIPE_DEPTH + 1;

    logic [PIPE_LATENCY-1:0] trk_vld_q, trk_vld_d;
    logic [ID_WIDTH-1:0]     trk_id_q  [PIPE_LATENCY];
    logic [BUCKET_BITS-1:0]  trk_bkt_q [PIPE_LATENCY];
    logic [ID_WIDTH-1:0]     rr_ptr_q, rr_ptr_d;
    logic [31:0]             stall_cnt_q, stall_cnt_d;

    logic [NUM_REQ-1:0]      eligible;
    logic [NUM_REQ-1:0]      grant;
    logic [ID_WIDTH-1:0]     grant_id;
    logic                    grant_any;

    // A request is held off while any valid tracker stage carries the same bucket.
    always_comb begin
        eligible = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            eligible[i] = req_valid[i];
            for (int s = 0; s < PIPE_LATENCY; s++) begin
                if (trk_vld_q[s] && (trk_bkt_q[s] == req_data[i*DATA_WIDTH +: BUCKET_BITS])) begin
                    eligible[i] = 1'b0;
                end
            end
        end
    end

    always_comb begin
        logic [ID_WIDTH-1:0] idx;
        grant     = '0;
        grant_id  = '0;
        grant_any = 1'b0;
        idx       = '0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            idx = ID_WIDTH'((int'(rr_ptr_q) + off) % NUM_REQ);
            if (!grant_any && eligible[idx]) begin
                grant[idx] = 1'b1;
                grant_id   = idx;
                grant_any  = 1'b1;
            end
        end
    end

    always_comb begin
        pipe_in_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                pipe_in_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign req_ready     = grant;
    assign pipe_in_valid = grant_any;

    always_comb begin
        trk_vld_d    = '0;
        trk_vld_d[0] = grant_any;
        for (int s = 1; s < PIPE_LATENCY; s++) begin
            trk_vld_d[s] = trk_vld_q[s-1];
        end
    end

    assign rr_ptr_d = grant_any ? grant_id : rr_ptr_q;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if ((|req_valid) && !grant_any && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            trk_vld_q   <= '0;
            rr_ptr_q    <= ID_WIDTH'(NUM_REQ - 1);
            stall_cnt_q <= '0;
            for (int s = 0; s < PIPE_LATENCY; s++) begin
                trk_id_q[s]  <= '0;
                trk_bkt_q[s] <= '0;
            end
        end else begin
            trk_vld_q    <= trk_vld_d;
            rr_ptr_q     <= rr_ptr_d;
            stall_cnt_q  <= stall_cnt_d;
            trk_id_q[0]  <= grant_id;
            trk_bkt_q[0] <= pipe_in_data[BUCKET_BITS-1:0];
            for (int s = 1; s < PIPE_LATENCY; s++) begin
                trk_id_q[s]  <= trk_id_q[s-1];
                trk_bkt_q[s] <= trk_bkt_q[s-1];
            end
        end
    end

    assign resp_valid  = trk_vld_q[PIPE_LATENCY-1];
    assign resp_id     = trk_vld_q[PIPE_LATENCY-1] ? trk_id_q[PIPE_LATENCY-1] : '0;
    assign resp_data   = pipe_out_data;
    assign busy        = |trk_vld_q;
    assign stall_count = stall_cnt_q;

endmodule
